parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
- Serial receiver and checker for parity-protected words produced by the team's 16-input XOR-tree parity generator.
- Deserialises a frame of start bit, DATA_W data bits (LSB first, bit 0 = input "a" of the generator), one parity bit and a stop bit.
- Recomputes parity, flags parity and framing errors, and keeps a saturating error counter.
- Sits at the far end of a serial link from the generator-side serialiser; output feeds downstream logic that consumes checked words.

Parameters:
- DATA_W, 16, number of data bits per frame (valid range 2..32).
- PARITY_ODD, 0, 0 = even parity (parity bit equals XOR of data bits), 1 = odd parity (parity bit equals inverted XOR).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_en  in  1  one-cycle strobe: rx_bit is sampled only in cycles where bit_en=1.
- rx_bit  in  1  serial line; idle level 1.
- clr_cnt  in  1  synchronous clear of err_cnt.
- data_o  out  DATA_W  last received data word.
- valid_o  out  1  one-cycle pulse: frame complete, data_o/par_err/frm_err are valid.
- par_err  out  1  parity mismatch on last frame.
- frm_err  out  1  stop bit sampled as 0 on last frame.
- busy  out  1  high while a frame is in progress (state != IDLE).
- err_cnt  out  CNT_W  count of frames with par_err or frm_err; saturates at all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; data_o=0; valid_o=0; par_err=0; frm_err=0; busy=0; err_cnt=0; shift register and bit counter cleared.
- Reset asserted mid-frame aborts the frame immediately: no valid_o, no counter update.
- All state transitions occur only on cycles with bit_en=1; otherwise state holds, except valid_o, which is driven low.
- IDLE: on rx_bit=0, go to DATA with bit index=0; rx_bit=1 stays in IDLE.
- DATA: shift rx_bit into bit[index] and accumulate running XOR; after the DATA_W-th bit, go to PARITY.
- PARITY: compute par_bad = rx_bit XOR running_xor XOR PARITY_ODD; go to STOP.
- STOP (on the strobe that samples the stop bit):
  - data_o <= assembled word.
  - par_err <= par_bad.
  - frm_err <= ~rx_bit.
  - valid_o <= 1 for exactly one clk cycle.
  - If par_bad or ~rx_bit, err_cnt increments by 1 unless already all-ones.
  - Next state is IDLE.
- Latency: valid_o rises on the clock edge that samples the stop bit (same edge as the data_o update).
- data_o, par_err and frm_err hold until the next frame completes.
- A frame with a stop error is still reported: data_o is updated and frm_err=1.
- No back-to-back start detection in STOP: a start bit is recognised only in IDLE, so the earliest new start is the strobe after the stop strobe.
- Back-to-back frames with no idle bit between them are supported: stop strobe then start strobe on consecutive bit_en pulses.
- bit_en held high every cycle is legal; one bit per clk.
- clr_cnt=1 sets err_cnt=0 on the next edge. If clr_cnt coincides with an error increment, the clear wins and err_cnt=0.
- Arithmetic: the running XOR is 1 bit; the bit index is $clog2(DATA_W) bits wide; err_cnt uses unsigned saturating add with no wrap.

Test Plan:
- Good even-parity frame, data 0xA5C3 (8 ones), parity 0, stop 1 -> valid_o pulse, data_o=0xA5C3, par_err=0, frm_err=0, err_cnt=0.
- Data 0x0001 with parity bit 0 (even mode) -> par_err=1, frm_err=0, err_cnt=1.
- PARITY_ODD=1, data 0xFFFF with parity 1 -> par_err=0.
- Data 0x1234 (5 ones) with parity 1 and stop 0 -> frm_err=1, par_err=0, data_o=0x1234, err_cnt increments.
- Deassert bit_en for 3 cycles between every bit -> same results as continuous strobe; valid_o stays one cycle wide.
- Remaining checks:
  - rst_n pulsed low after 7 data bits -> all outputs 0 and no valid_o; the next clean frame is received correctly.
  - Force 300 bad frames (CNT_W=8) -> err_cnt saturates at 255.
  - clr_cnt coincident with an error frame -> err_cnt=0.

Source files
------------

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: deserialises start/data/parity/stop frames, checks parity and stop bit, counts errors
module parity_frame_rx #(
  parameter int DATA_W     = 16,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_bit,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int IW = $clog2(DATA_W);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic              xor_q, xor_d, bad_q, bad_d, valid_q, valid_d;
  logic              par_q, par_d, frm_q, frm_d, err_hit;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    xor_d   = xor_q;
    bad_d   = bad_q;
    data_d  = data_q;
    par_d   = par_q;
    frm_d   = frm_q;
    valid_d = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: if (!rx_bit) begin
          state_d = DATA;
          idx_d   = '0;
          xor_d   = 1'b0;
        end
        DATA: begin
          shift_d[idx_q] = rx_bit;
          xor_d          = xor_q ^ rx_bit;
          idx_d          = idx_q + IW'(1);
          state_d        = (idx_q == IW'(DATA_W - 1)) ? PARITY : DATA;
        end
        PARITY: begin
          bad_d   = rx_bit ^ xor_q ^ 1'(PARITY_ODD);
          state_d = STOP;
        end
        default: begin
          data_d  = shift_q;
          par_d   = bad_q;
          frm_d   = ~rx_bit;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
    err_hit = bit_en && state_q == STOP && (bad_q || !rx_bit);
    // clear has priority over a coincident error increment
    cnt_d = clr_cnt ? '0 : (err_hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      xor_q   <= 1'b0;
      bad_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      xor_q   <= xor_d;
      bad_q   <= bad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
      cnt_q   <= cnt_d;
    end
  end
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign par_err = par_q;
  assign frm_err = frm_q;
  assign busy    = state_q != IDLE;
  assign err_cnt = cnt_q;
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed frames against an even-parity and an odd-parity receiver
module tb_parity_frame_rx;
  logic clk = 1'b0, rst_n = 1'b0, bit_en = 1'b0, rx_bit = 1'b1, clr_cnt = 1'b0;
  logic [15:0] data_e, data_od;
  logic valid_e, par_e, frm_e, busy_e, valid_od, par_od, frm_od, busy_od;
  logic [7:0] cnt_e, cnt_od;
  int errors = 0, checks = 0;

  parity_frame_rx #(.DATA_W(16), .PARITY_ODD(0), .CNT_W(8)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_bit(rx_bit), .clr_cnt(clr_cnt),
    .data_o(data_e), .valid_o(valid_e), .par_err(par_e), .frm_err(frm_e),
    .busy(busy_e), .err_cnt(cnt_e));
  parity_frame_rx #(.DATA_W(16), .PARITY_ODD(1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_bit(rx_bit), .clr_cnt(clr_cnt),
    .data_o(data_od), .valid_o(valid_od), .par_err(par_od), .frm_err(frm_od),
    .busy(busy_od), .err_cnt(cnt_od));

  always #5 clk = ~clk;

  task automatic send_bit(input logic b, input int gap);
    bit_en = 1'b1;
    rx_bit = b;
    @(posedge clk); #1;
    bit_en = 1'b0;
    rx_bit = 1'b1;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // stop bit goes out with no trailing gap so the caller can sample valid_o right after it
  task automatic send_frame(input logic [15:0] d, input logic p, input logic s, input int gap, input logic clr);
    send_bit(1'b0, gap);
    for (int i = 0; i < 16; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    clr_cnt = clr;
    send_bit(s, 0);
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({data_e, valid_e, par_e, frm_e, busy_e, cnt_e} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state got data=%h v=%b p=%b f=%b busy=%b cnt=%0d exp all 0", data_e, valid_e, par_e, frm_e, busy_e, cnt_e);
    end
  endtask

  task automatic test_good_frame;
    send_frame(16'hA5C3, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if ({valid_e, data_e, par_e, frm_e, cnt_e} !== {1'b1, 16'hA5C3, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL good_frame got v=%b data=%h p=%b f=%b cnt=%0d exp v=1 data=a5c3 p=0 f=0 cnt=0", valid_e, data_e, par_e, frm_e, cnt_e);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_e !== 1'b0 || busy_e !== 1'b0) begin
      errors++;
      $display("FAIL good_frame_pulse got v=%b busy=%b exp 0 0", valid_e, busy_e);
    end
  endtask

  task automatic test_parity_error;
    send_frame(16'h0001, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if ({valid_e, data_e, par_e, frm_e, cnt_e} !== {1'b1, 16'h0001, 1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL parity_error got v=%b data=%h p=%b f=%b cnt=%0d exp v=1 data=0001 p=1 f=0 cnt=1", valid_e, data_e, par_e, frm_e, cnt_e);
    end
  endtask

  task automatic test_odd_parity;
    send_frame(16'hFFFF, 1'b1, 1'b1, 0, 1'b0);
    checks++;
    if ({valid_od, data_od, par_od, frm_od} !== {1'b1, 16'hFFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL odd_parity got v=%b data=%h p=%b f=%b exp v=1 data=ffff p=0 f=0", valid_od, data_od, par_od, frm_od);
    end
    checks++;
    if (par_e !== 1'b1 || cnt_e !== 8'd2) begin
      errors++;
      $display("FAIL odd_frame_on_even got p=%b cnt=%0d exp p=1 cnt=2", par_e, cnt_e);
    end
  endtask

  task automatic test_framing_error;
    send_frame(16'h1234, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    if ({valid_e, data_e, par_e, frm_e, cnt_e} !== {1'b1, 16'h1234, 1'b0, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL framing_error got v=%b data=%h p=%b f=%b cnt=%0d exp v=1 data=1234 p=0 f=1 cnt=3", valid_e, data_e, par_e, frm_e, cnt_e);
    end
  endtask

  task automatic test_gapped;
    send_bit(1'b0, 3);
    for (int i = 0; i < 7; i++) send_bit(1'(16'hA5C3 >> i), 3);
    checks++;
    if (busy_e !== 1'b1 || valid_e !== 1'b0) begin
      errors++;
      $display("FAIL gapped_busy got busy=%b v=%b exp 1 0", busy_e, valid_e);
    end
    for (int i = 7; i < 16; i++) send_bit(1'(16'hA5C3 >> i), 3);
    send_bit(1'b0, 3);
    send_bit(1'b1, 0);
    checks++;
    if ({valid_e, data_e, par_e, frm_e, cnt_e} !== {1'b1, 16'hA5C3, 1'b0, 1'b0, 8'd3}) begin
      errors++;
      $display("FAIL gapped_frame got v=%b data=%h p=%b f=%b cnt=%0d exp v=1 data=a5c3 p=0 f=0 cnt=3", valid_e, data_e, par_e, frm_e, cnt_e);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_e !== 1'b0 || data_e !== 16'hA5C3) begin
      errors++;
      $display("FAIL gapped_pulse got v=%b data=%h exp v=0 data=a5c3", valid_e, data_e);
    end
  endtask

  task automatic test_reset_mid_frame;
    int seen = 0;
    send_bit(1'b0, 0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({data_e, valid_e, par_e, frm_e, busy_e, cnt_e} !== 28'd0) begin
      errors++;
      $display("FAIL reset_mid_frame got data=%h v=%b p=%b f=%b busy=%b cnt=%0d exp all 0", data_e, valid_e, par_e, frm_e, busy_e, cnt_e);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bit_en = 1'b1;
      @(posedge clk); #1;
      if (valid_e) seen++;
    end
    bit_en = 1'b0;
    checks++;
    if (seen !== 0 || busy_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_valid got pulses=%0d busy=%b exp 0 0", seen, busy_e);
    end
    send_frame(16'h5A3C, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if ({valid_e, data_e, par_e, frm_e, cnt_e} !== {1'b1, 16'h5A3C, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL post_reset_frame got v=%b data=%h p=%b f=%b cnt=%0d exp v=1 data=5a3c p=0 f=0 cnt=0", valid_e, data_e, par_e, frm_e, cnt_e);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(16'h00FF, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (valid_e !== 1'b1 || data_e !== 16'h00FF || par_e !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got v=%b data=%h p=%b exp v=1 data=00ff p=0", valid_e, data_e, par_e);
    end
    send_frame(16'h8001, 1'b1, 1'b1, 0, 1'b0);
    checks++;
    if ({valid_e, data_e, par_e, frm_e, cnt_e} !== {1'b1, 16'h8001, 1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL b2b_second got v=%b data=%h p=%b f=%b cnt=%0d exp v=1 data=8001 p=1 f=0 cnt=1", valid_e, data_e, par_e, frm_e, cnt_e);
    end
  endtask

  task automatic test_saturation;
    for (int n = 0; n < 300; n++) send_frame(16'(n), ~^16'(n), 1'b1, 0, 1'b0);
    checks++;
    if (cnt_e !== 8'd255 || par_e !== 1'b1) begin
      errors++;
      $display("FAIL saturation got cnt=%0d p=%b exp cnt=255 p=1", cnt_e, par_e);
    end
  endtask

  task automatic test_clear;
    send_frame(16'h0003, 1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (cnt_e !== 8'd0 || par_e !== 1'b1 || frm_e !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_error got cnt=%0d p=%b f=%b exp cnt=0 p=1 f=1", cnt_e, par_e, frm_e);
    end
    send_frame(16'h0007, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (cnt_e !== 8'd1 || par_e !== 1'b1) begin
      errors++;
      $display("FAIL count_after_clear got cnt=%0d p=%b exp cnt=1 p=1", cnt_e, par_e);
    end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_good_frame;
    test_parity_error;
    test_odd_parity;
    test_framing_error;
    test_gapped;
    test_reset_mid_frame;
    test_back_to_back;
    test_saturation;
    test_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
